// File: rtl/aoi_sweep_pkg.sv
// ----------------------------------------------------------------------------
// aoi_sweep_pkg
// Shared definitions for the AOI sweep driver and its golden checker.
//   state_t      : sweeper FSM states (IDLE, DRIVE, DONE)
//   AOI_GOLDEN   : expected truth table of ~((A&B)|(C&D)), bit i = pattern i
//   NUM_PATTERNS : number of input patterns swept (all 4-bit combinations)
//   aoi_golden   : golden gate value for one pattern {A,B,C,D}
// ----------------------------------------------------------------------------
package aoi_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [15:0] AOI_GOLDEN   = 16'h0777;
  localparam int          NUM_PATTERNS = 16;

  // Pattern bit 3 is A, bit 0 is D.
  function automatic logic aoi_golden(input logic [3:0] i_pat);
    return AOI_GOLDEN[i_pat];
  endfunction

endpackage

// File: rtl/aoi_sweep_driver_check.sv
// ----------------------------------------------------------------------------
// aoi_golden_check
// Golden AOI comparator plus registered mismatch accumulator.
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   i_clear        : clears the accumulator (new sweep starting)
//   i_capture      : a captured sample is presented this cycle
//   i_idx          : pattern index of the captured sample
//   i_sample       : captured gate output
//   o_mismatch_cnt : number of captures differing from golden (0..16)
// ----------------------------------------------------------------------------
module aoi_golden_check
  import aoi_sweep_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_capture,
  input  logic [3:0] i_idx,
  input  logic       i_sample,
  output logic [4:0] o_mismatch_cnt
);

  logic       w_golden;
  logic       w_differs;
  logic [4:0] r_mismatch_cnt;

  assign w_golden  = aoi_golden(i_idx);
  assign w_differs = i_capture && (i_sample != w_golden);

  // At most 16 captures per sweep, so 5 bits never wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_mismatch_cnt <= 5'd0;
    end else if (w_differs) begin
      r_mismatch_cnt <= r_mismatch_cnt + 5'd1;
    end
  end

  assign o_mismatch_cnt = r_mismatch_cnt;

endmodule

// File: rtl/four_aoi.sv
// ----------------------------------------------------------------------------
// four_aoi
// Four-input and-or-invert gate being characterised by the sweep driver.
//   inA, inB, inC, inD : gate inputs
//   outG               : ~((inA & inB) | (inC & inD))
// ----------------------------------------------------------------------------
module four_aoi (
  input  logic inA,
  input  logic inB,
  input  logic inC,
  input  logic inD,
  output logic outG
);

  assign outG = ~((inA & inB) | (inC & inD));

endmodule

// File: rtl/aoi_sweep_driver.sv
// ----------------------------------------------------------------------------
// aoi_sweep_driver
// Clocked stimulus-and-capture stage for the four_aoi gate. Drives all 16
// input patterns, holds each for HOLD_CYCLES clocks, samples outG on the last
// edge of each hold window into truth_table, and reports completion.
//
// Build option: define AOI_SWEEP_CHECK_EN to compile in the golden comparator
// and mismatch accumulator. Without it mismatch_cnt is 0 and pass == done.
//
// Parameters:
//   HOLD_CYCLES  : clocks each pattern is held (2..255)
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   start        : one-cycle sweep request, honoured in IDLE or DONE
//   outG         : gate output being characterised
//   inA..inD     : registered pattern bits 3..0 (0 outside DRIVE)
//   busy         : sweep in progress
//   done         : sweep complete, held until next start or reset
//   truth_table  : bit i = outG captured for pattern i
//   mismatch_cnt : captures differing from golden
//   pass         : done with no mismatches
// ----------------------------------------------------------------------------
module aoi_sweep_driver
  import aoi_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        outG,
  output logic        inA,
  output logic        inB,
  output logic        inC,
  output logic        inD,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_cnt,
  output logic        pass
);

  localparam logic [7:0] LP_HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0] LP_IDX_LAST  = 4'(NUM_PATTERNS - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [7:0]  r_hold;
  logic [3:0]  r_pat;
  logic [15:0] r_truth_table;

  state_t      w_nxt_state;
  logic [3:0]  w_nxt_idx;
  logic [7:0]  w_nxt_hold;
  logic        w_capture;
  logic        w_clear;
  logic [3:0]  w_nxt_pat;

  // Next-state and control decode
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_hold  = r_hold;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_nxt_state = ST_DRIVE;
          w_nxt_idx   = 4'd0;
          w_nxt_hold  = 8'd0;
          w_clear     = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (r_hold != LP_HOLD_LAST) begin
          w_nxt_hold = r_hold + 8'd1;
        end else begin
          w_capture  = 1'b1;
          w_nxt_hold = 8'd0;
          if (r_idx == LP_IDX_LAST) begin
            w_nxt_state = ST_DONE;
          end else begin
            w_nxt_idx = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_idx   = 4'd0;
        w_nxt_hold  = 8'd0;
      end
    endcase
  end

  // Pattern is registered from the next-state view so the gate inputs change
  // cleanly on the clock edge, with no decode logic after the flops.
  assign w_nxt_pat = (w_nxt_state == ST_DRIVE) ? w_nxt_idx : 4'd0;

  // State, pattern and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= 4'd0;
      r_hold        <= 8'd0;
      r_pat         <= 4'd0;
      r_truth_table <= 16'h0000;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_hold  <= w_nxt_hold;
      r_pat   <= w_nxt_pat;
      if (w_clear) begin
        r_truth_table <= 16'h0000;
      end else if (w_capture) begin
        r_truth_table[r_idx] <= outG;
      end
    end
  end

  assign inA         = r_pat[3];
  assign inB         = r_pat[2];
  assign inC         = r_pat[1];
  assign inD         = r_pat[0];
  assign busy        = (r_state == ST_DRIVE);
  assign done        = (r_state == ST_DONE);
  assign truth_table = r_truth_table;

`ifdef AOI_SWEEP_CHECK_EN
  logic [4:0] w_mismatch_cnt;

  aoi_golden_check u_check (
    .clk            (clk),
    .rst            (rst),
    .i_clear        (w_clear),
    .i_capture      (w_capture),
    .i_idx          (r_idx),
    .i_sample       (outG),
    .o_mismatch_cnt (w_mismatch_cnt)
  );

  assign mismatch_cnt = w_mismatch_cnt;
  assign pass         = done && (w_mismatch_cnt == 5'd0);
`else
  assign mismatch_cnt = 5'd0;
  assign pass         = done;
`endif

endmodule

// File: tb/tb_aoi_sweep_driver.sv
module tb_aoi_sweep_driver;

  localparam int H  = 4;
  localparam int H2 = 2;
  localparam logic [15:0] GOLD = 16'h0777;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2;
  logic [1:0]  mode;
  logic        inA, inB, inC, inD, busy, done, pass;
  logic [15:0] tt;
  logic [4:0]  mis;
  logic        g, outG;

  logic        inA2, inB2, inC2, inD2, busy2, done2, pass2, g2;
  logic [15:0] tt2;
  logic [4:0]  mis2;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  logic chk_en = 1'b0;

  aoi_sweep_driver #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start), .outG(outG),
    .inA(inA), .inB(inB), .inC(inC), .inD(inD),
    .busy(busy), .done(done), .truth_table(tt),
    .mismatch_cnt(mis), .pass(pass)
  );
  four_aoi gate (.inA(inA), .inB(inB), .inC(inC), .inD(inD), .outG(g));

  // mode 0: real gate, 1: stuck at 0, 2: inverted gate
  always_comb begin
    outG = g;
    if (mode == 2'd1) outG = 1'b0;
    else if (mode == 2'd2) outG = ~g;
  end

  aoi_sweep_driver #(.HOLD_CYCLES(H2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .outG(g2),
    .inA(inA2), .inB(inB2), .inC(inC2), .inD(inD2),
    .busy(busy2), .done(done2), .truth_table(tt2),
    .mismatch_cnt(mis2), .pass(pass2)
  );
  four_aoi gate2 (.inA(inA2), .inB(inB2), .inC(inC2), .inD(inD2), .outG(g2));

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic gate_model(input logic [1:0] md, input logic [3:0] p);
    logic gv;
    gv = ~((p[3] & p[2]) | (p[1] & p[0]));
    if (md == 2'd1) return 1'b0;
    if (md == 2'd2) return ~gv;
    return gv;
  endfunction

  function automatic int popcnt(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  // Behavioural model: time since start n; pattern = n / H; capture on the
  // last cycle of each hold window; finished after 16*H cycles.
  logic        m_run, m_done;
  int          m_n;
  logic [15:0] m_tt, m_cap;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_done <= 1'b0; m_n <= 0; m_tt <= '0; m_cap <= '0;
    end else if (!m_run && start) begin
      m_run <= 1'b1; m_done <= 1'b0; m_n <= 0; m_tt <= '0; m_cap <= '0;
    end else if (m_run) begin
      if (m_n % H == H - 1) begin
        m_tt[m_n / H]  <= gate_model(mode, 4'(m_n / H));
        m_cap[m_n / H] <= 1'b1;
      end
      if (m_n == 16 * H - 1) begin
        m_run <= 1'b0; m_done <= 1'b1;
      end
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] ep;
      int         em;
      ep = m_run ? 4'(m_n / H) : 4'd0;
`ifdef AOI_SWEEP_CHECK_EN
      em = popcnt((m_tt ^ GOLD) & m_cap);
`else
      em = 0;
`endif
      chk("pattern", {28'd0, inA, inB, inC, inD}, {28'd0, ep});
      chk("busy", {31'd0, busy}, {31'd0, m_run});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("truth_table", {16'd0, tt}, {16'd0, m_tt});
      chk("mismatch_cnt", {27'd0, mis}, em);
      chk("pass", {31'd0, pass}, {31'd0, m_done && (em == 0)});
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int ks, input int h, input string name);
    while (!done && (cyc - ks) < 1000) @(negedge clk);
    chk(name, cyc - ks, 16 * h);
  endtask

  int ks;
  int exp_mis_stuck, exp_mis_inv, exp_pass_bad;

  initial begin
`ifdef AOI_SWEEP_CHECK_EN
    exp_mis_stuck = 9; exp_mis_inv = 16; exp_pass_bad = 0;
`else
    exp_mis_stuck = 0; exp_mis_inv = 0; exp_pass_bad = 1;
`endif
    rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_pattern", {28'd0, inA, inB, inC, inD}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_pass", {31'd0, pass}, 0);
    chk("rst_tt", {16'd0, tt}, 0);
    chk("rst_mis", {27'd0, mis}, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Real gate, full sweep
    pulse_start(); ks = cyc;
    chk("t1_busy", {31'd0, busy}, 1);
    wait_done(ks, H, "t1_latency");
    chk("t1_tt", {16'd0, tt}, 32'h0777);
    chk("t1_mis", {27'd0, mis}, 0);
    chk("t1_pass", {31'd0, pass}, 1);

    // Restart from DONE with outG stuck at 0
    mode = 2'd1;
    pulse_start(); ks = cyc;
    chk("t2_done_drop", {31'd0, done}, 0);
    chk("t2_clear", {16'd0, tt}, 0);
    wait_done(ks, H, "t2_latency");
    chk("t2_tt", {16'd0, tt}, 32'h0000);
    chk("t2_mis", {27'd0, mis}, exp_mis_stuck);
    chk("t2_pass", {31'd0, pass}, exp_pass_bad);

    // Inverted gate output
    mode = 2'd2;
    pulse_start(); ks = cyc;
    wait_done(ks, H, "t3_latency");
    chk("t3_tt", {16'd0, tt}, 32'hF888);
    chk("t3_mis", {27'd0, mis}, exp_mis_inv);
    chk("t3_pass", {31'd0, pass}, exp_pass_bad);

    // Reset mid-sweep at pattern 5
    mode = 2'd0;
    pulse_start(); ks = cyc;
    repeat (21) @(negedge clk);
    chk("t4_at5", {28'd0, inA, inB, inC, inD}, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_pattern", {28'd0, inA, inB, inC, inD}, 0);
    chk("t4_busy", {31'd0, busy}, 0);
    chk("t4_tt", {16'd0, tt}, 0);
    chk("t4_done", {31'd0, done}, 0);
    pulse_start(); ks = cyc;
    wait_done(ks, H, "t4_latency");
    chk("t4_tt_full", {16'd0, tt}, 32'h0777);

    // Start re-pulsed during DRIVE at pattern 3 is ignored
    pulse_start(); ks = cyc;
    repeat (13) @(negedge clk);
    chk("t5_at3", {28'd0, inA, inB, inC, inD}, 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ks, H, "t5_latency");
    chk("t5_tt", {16'd0, tt}, 32'h0777);

    // HOLD_CYCLES = 2 instance
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    for (int c = 0; c < 16 * H2; c++) begin
      chk("h2_pattern", {28'd0, inA2, inB2, inC2, inD2}, c / H2);
      chk("h2_busy", {31'd0, busy2, done2}, 32'b10);
      @(negedge clk);
    end
    chk("h2_done", {30'd0, busy2, done2}, 32'b01);
    chk("h2_tt", {16'd0, tt2}, 32'h0777);
    chk("h2_mis", {27'd0, mis2}, 0);
    chk("h2_pass", {31'd0, pass2}, 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
